phy_tx: RTL and testbench



---
 rtl/phy_pkg.sv | 20 ++
 rtl/phy_tx_lane_piso.sv | 30 +++
 rtl/phy_tx.sv | 75 +++++++
 tb/tb_phy_tx.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/phy_pkg.sv
// Shared definitions for the two-lane PHY: slot geometry, idle symbol and link state.
// The transmitter and the receiver aligner both import this package.
package phy_pkg;

  localparam logic [7:0] COM_SYMBOL_DEFAULT = 8'hBC;
  localparam int         SLOT_BITS          = 16;
  localparam int         LANES              = 2;
  localparam int         CNT_W              = $clog2(SLOT_BITS);

  typedef enum logic {
    ST_PREAMBLE,
    ST_ACTIVE
  } link_state_t;

  // Lane 0 carries bytes 3 and 1 of the word, lane 1 carries bytes 2 and 0.
  function automatic logic [SLOT_BITS-1:0] lane_bytes(input logic [31:0] word, input int lane);
    return (lane == 0) ? {word[31:24], word[15:8]} : {word[23:16], word[7:0]};
  endfunction

endpackage

// File: rtl/phy_tx_lane_piso.sv
// One lane of the transmitter: a slot-wide parallel-load shift register.
// The serial bit is the register MSB, so the lane pin is driven straight from a flop.
module phy_tx_lane_piso
  import phy_pkg::*;
(
  input  logic                 clk_32f,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 shift,
  input  logic [SLOT_BITS-1:0] slot_word,
  output logic                 serial
);

  logic [SLOT_BITS-1:0] sreg;

  // NOTE: the shift register is ordinary control state, so it is cleared on reset
  // to keep the lane pins quiet while the link is held in reset.
  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= slot_word;
    end else if (shift) begin
      sreg <= {sreg[SLOT_BITS-2:0], 1'b0};
    end
  end

  assign serial = sreg[SLOT_BITS-1];

endmodule

// File: rtl/phy_tx.sv
// Transmit half of the two-lane PHY: stripes 32-bit words across two serial lanes,
// one slot (16 bits per lane) per word, with COM fill for preamble and idle slots.
module phy_tx
  import phy_pkg::*;
#(
  parameter logic [7:0] COM_SYMBOL     = COM_SYMBOL_DEFAULT,
  parameter int         PREAMBLE_WORDS = 2
) (
  input  logic        clk_32f,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic        data_out_0,
  output logic        data_out_1,
  output logic        active_out
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_BITS - 1);
  localparam logic [3:0]       PRE_LAST = 4'(PREAMBLE_WORDS - 1);

  link_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       pre_cnt;
  logic             boundary;
  logic             accept;
  logic [LANES-1:0] lane_bit;

  // The slot boundary is the edge on which cnt wraps; both lanes reload there.
  assign boundary  = (cnt == CNT_LAST);
  assign ready_out = (state == ST_ACTIVE) && boundary;
  assign accept    = ready_out && valid_in;

  // NOTE: all state here updates with non-blocking assignments so every flop
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      state      <= ST_PREAMBLE;
      cnt        <= CNT_LAST;
      pre_cnt    <= '0;
      active_out <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      if (boundary) begin
        active_out <= accept;
        if (state == ST_PREAMBLE) begin
          pre_cnt <= pre_cnt + 4'd1;
          if (pre_cnt == PRE_LAST) begin
            state <= ST_ACTIVE;
          end
        end
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [SLOT_BITS-1:0] slot_word;

    // Data bytes equal to COM go out unmodified; alignment only uses the preamble.
    assign slot_word = accept ? lane_bytes(data_in, l) : {COM_SYMBOL, COM_SYMBOL};

    phy_tx_lane_piso u_piso (
      .clk_32f  (clk_32f),
      .reset    (reset),
      .load     (boundary),
      .shift    (!boundary),
      .slot_word(slot_word),
      .serial   (lane_bit[l])
    );
  end

  assign data_out_0 = lane_bit[0];
  assign data_out_1 = lane_bit[1];

endmodule

// File: tb/tb_phy_tx.sv
// Self-checking bench for phy_tx: directed scenarios plus random traffic, checked
// cycle by cycle against a slot-level reference model and a word deserializer.
module tb_phy_tx;

  localparam int         PRE = 2;
  localparam logic [7:0] COM = 8'hBC;

  logic        clk_32f  = 1'b0;
  logic        reset    = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] data_in  = '0;
  logic        ready_out, data_out_0, data_out_1, active_out;

  int checks   = 0;
  int failures = 0;

  phy_tx #(.COM_SYMBOL(COM), .PREAMBLE_WORDS(PRE)) dut (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .data_out_0(data_out_0),
    .data_out_1(data_out_1),
    .active_out(active_out)
  );

  always #5 clk_32f = ~clk_32f;

  // Reference model: e counts edges since reset release; every 16th edge starts a slot.
  int          e       = -1;
  bit          m_known = 1'b0;
  logic [15:0] m_slot0 = '0;
  logic [15:0] m_slot1 = '0;
  logic        m_active = 1'b0;
  bit          acc;
  int          acc_e;
  logic [31:0] sent_q[$];
  logic [15:0] des0, des1;
  int          des_n = 0;
  logic        exp_b0, exp_b1, exp_rdy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    logic [31:0] w;
    @(posedge clk_32f);
    acc = 1'b0;
    if (!reset) begin
      e        = -1;
      m_slot0  = '0;
      m_slot1  = '0;
      m_active = 1'b0;
      m_known  = 1'b1;
      des_n    = 0;
      sent_q.delete();
    end else if (m_known) begin
      e++;
      if (e % 16 == 0) begin
        if (e >= PRE * 16 && valid_in) begin
          m_slot0  = {data_in[31:24], data_in[15:8]};
          m_slot1  = {data_in[23:16], data_in[7:0]};
          m_active = 1'b1;
          acc      = 1'b1;
          acc_e    = e;
          sent_q.push_back(data_in);
        end else begin
          m_slot0  = {COM, COM};
          m_slot1  = {COM, COM};
          m_active = 1'b0;
        end
      end
    end
    #1;
    if (m_known) begin
      exp_b0  = (e < 0) ? 1'b0 : m_slot0[15 - (e % 16)];
      exp_b1  = (e < 0) ? 1'b0 : m_slot1[15 - (e % 16)];
      exp_rdy = (e >= 0) && ((e + 1) % 16 == 0) && (e + 1 >= PRE * 16);
      check("lane0_bit", data_out_0, exp_b0);
      check("lane1_bit", data_out_1, exp_b1);
      check("ready", ready_out, exp_rdy);
      check("active", active_out, m_active);
      // Loopback-style deserializer: rebuild words from active slots.
      if (active_out) begin
        des0 = {des0[14:0], data_out_0};
        des1 = {des1[14:0], data_out_1};
        des_n++;
        if (des_n == 16) begin
          des_n = 0;
          w = {des0[15:8], des1[15:8], des0[7:0], des1[7:0]};
          check("word_pending", sent_q.size(), 1);
          if (sent_q.size() > 0) check("word_rx", w, sent_q.pop_front());
        end
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  // Offer a word until accepted (bounded); optionally keep valid_in high afterwards.
  task automatic send(input logic [31:0] w, input bit hold);
    bit got;
    got      = 1'b0;
    valid_in = 1'b1;
    data_in  = w;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      got = acc;
    end
    check("accept_in_time", got, 1);
    if (!hold) valid_in = 1'b0;
  endtask

  // Capture n serial bits per lane, starting with the bits currently on the pins.
  task automatic capture(input int n, output logic [31:0] l0, output logic [31:0] l1);
    l0 = '0;
    l1 = '0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) tick();
      l0 = {l0[30:0], data_out_0};
      l1 = {l1[30:0], data_out_1};
    end
  endtask

  logic [31:0] c0, c1;
  int          prev_e, n_acc;

  initial begin
    // Reset held for 5 cycles, then the 2-slot preamble.
    reset = 1'b0;
    run(5);
    check("rst_lane0", data_out_0, 0);
    check("rst_ready", ready_out, 0);
    reset = 1'b1;
    tick();
    capture(32, c0, c1);
    check("preamble_lane0", c0, 32'hBCBC_BCBC);
    check("preamble_lane1", c1, 32'hBCBC_BCBC);
    check("first_ready_e31", ready_out, 1);

    // Single word at the first ready.
    send(32'hA1B2_C3D4, 1'b0);
    check("first_accept_edge", acc_e, 32);
    capture(16, c0, c1);
    check("a1_lane0", c0[15:0], 16'hA1C3);
    check("a1_lane1", c1[15:0], 16'hB2D4);
    run(20);

    // Back-to-back words with valid held high.
    for (int k = 1; k <= 4; k++) begin
      send(32'(k), k != 4);
      if (k > 1) check("b2b_spacing", acc_e - prev_e, 16);
      prev_e = acc_e;
    end
    run(40);

    // valid pulsed only away from the accept cycle: nothing may be taken.
    n_acc = 0;
    for (int i = 0; i < 64; i++) begin
      exp_rdy  = ((e + 1) % 16 == 0) && (e + 1 >= PRE * 16);
      valid_in = !exp_rdy && ($urandom_range(0, 1) == 1);
      data_in  = $urandom;
      tick();
      if (acc) n_acc++;
    end
    valid_in = 1'b0;
    check("pulse_accepts", n_acc, 0);
    check("pulse_active", active_out, 0);

    // Reset at bit 7 of a data slot, with a word offered during reset.
    run(3);
    send(32'hFFFF_FFFF, 1'b0);
    run(7);
    reset    = 1'b0;
    valid_in = 1'b1;
    data_in  = 32'h1234_5678;
    tick();
    check("midrst_lane0", data_out_0, 0);
    check("midrst_lane1", data_out_1, 0);
    reset    = 1'b1;
    valid_in = 1'b0;
    tick();
    capture(32, c0, c1);
    check("repreamble_lane0", c0, 32'hBCBC_BCBC);
    check("repreamble_lane1", c1, 32'hBCBC_BCBC);

    // A data word that looks like COM is still data.
    send(32'hBCBC_BCBC, 1'b0);
    check("com_word_active", active_out, 1);
    capture(16, c0, c1);
    check("com_word_lane0", c0[15:0], 16'hBCBC);
    check("com_word_active_end", active_out, 1);
    run(20);

    // Random traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      reset    = ($urandom_range(0, 399) != 0);
      valid_in = ($urandom_range(0, 2) != 0);
      data_in  = $urandom;
      tick();
    end
    reset    = 1'b1;
    valid_in = 1'b0;
    run(40);
    check("queue_drained", sent_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
